// File: rtl/sft_pipe_multi.sv
// Pipelined multi-mode barrel shifter (LSL / LSR / ASR / ROL).
// One register slice per log-shift stage, largest shift first, valid/ready
// flow control with bubble collapsing. Latency is SEL_WIDTH cycles.
// Optional feature macro: SFT_PIPE_STICKY_EN adds a per-beat sticky bit (OR of
// bits discarded by LSR/ASR); without it out_sticky is tied low.
module sft_pipe_multi #(
    parameter int unsigned D_WIDTH   = 16,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   in_data,
    input  logic [SEL_WIDTH-1:0] in_sel,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_WIDTH-1:0]   out_data,
    output logic                 out_sticky
);

    localparam int unsigned NumStages = SEL_WIDTH;

    localparam logic [1:0] ModeLsl = 2'b00;
    localparam logic [1:0] ModeLsr = 2'b01;
    localparam logic [1:0] ModeAsr = 2'b10;
    localparam logic [1:0] ModeRol = 2'b11;

    typedef logic [D_WIDTH-1:0]   data_t;
    typedef logic [SEL_WIDTH-1:0] sel_t;

    // Shift by a fixed stage amount k; ASR fills with the sign captured at input.
    function automatic data_t shift_stage(input data_t d, input logic [1:0] mode,
                                          input logic sign, input int unsigned k);
        data_t ones;
        data_t res;
        ones = '1;
        res  = d;
        unique case (mode)
            ModeLsl: res = d << k;
            ModeLsr: res = d >> k;
            ModeAsr: res = (d >> k) | (sign ? ~(ones >> k) : '0);
            ModeRol: res = (d << k) | (d >> (D_WIDTH - k));
            default: res = d;
        endcase
        return res;
    endfunction

`ifdef SFT_PIPE_STICKY_EN
    // True when a right shift by k drops any set bit.
    function automatic logic lost_bits(input data_t d, input logic [1:0] mode,
                                       input int unsigned k);
        data_t ones;
        ones = '1;
        return ((mode == ModeLsr) || (mode == ModeAsr)) && ((d & ~(ones << k)) != '0);
    endfunction
`endif

    // Stage registers
    data_t                data_q [NumStages];
    data_t                data_d [NumStages];
    sel_t                 sel_q  [NumStages];
    sel_t                 sel_d  [NumStages];
    logic [1:0]           mode_q [NumStages];
    logic [1:0]           mode_d [NumStages];
    logic [NumStages-1:0] sign_q;
    logic [NumStages-1:0] sign_d;
    logic [NumStages-1:0] valid_q;
    logic [NumStages-1:0] valid_d;
`ifdef SFT_PIPE_STICKY_EN
    logic [NumStages-1:0] sticky_q;
    logic [NumStages-1:0] sticky_d;
    logic [NumStages-1:0] src_sticky;
`endif

    // Per-stage upstream view: stage 0 sees the input port, stage s sees slice s-1
    data_t                src_data [NumStages];
    sel_t                 src_sel  [NumStages];
    logic [1:0]           src_mode [NumStages];
    logic [NumStages-1:0] src_sign;
    logic [NumStages-1:0] src_valid;
    logic [NumStages-1:0] adv;

    // Route each stage's source beat
    always_comb begin
        src_data[0]  = in_data;
        src_sel[0]   = in_sel;
        src_mode[0]  = in_mode;
        src_sign[0]  = in_data[D_WIDTH-1];
        src_valid[0] = in_valid;
`ifdef SFT_PIPE_STICKY_EN
        src_sticky[0] = 1'b0;
`endif
        for (int s = 1; s < NumStages; s++) begin
            src_data[s]  = data_q[s-1];
            src_sel[s]   = sel_q[s-1];
            src_mode[s]  = mode_q[s-1];
            src_sign[s]  = sign_q[s-1];
            src_valid[s] = valid_q[s-1];
`ifdef SFT_PIPE_STICKY_EN
            src_sticky[s] = sticky_q[s-1];
`endif
        end
    end

    // Stage s may load when any slice from s to the output is empty or the output drains;
    // written without a ripple through adv itself to keep the chain acyclic.
    always_comb begin
        for (int s = 0; s < NumStages; s++) begin
            adv[s] = out_ready || ((~valid_q >> s) != '0);
        end
    end

    assign in_ready = adv[0];

    // Next-state for every slice; flush overrides all valids
    always_comb begin
        for (int s = 0; s < NumStages; s++) begin
            data_d[s]  = data_q[s];
            sel_d[s]   = sel_q[s];
            mode_d[s]  = mode_q[s];
            sign_d[s]  = sign_q[s];
            valid_d[s] = valid_q[s];
`ifdef SFT_PIPE_STICKY_EN
            sticky_d[s] = sticky_q[s];
`endif
            if (adv[s]) begin
                valid_d[s] = src_valid[s];
                if (src_valid[s]) begin
                    sel_d[s]  = src_sel[s];
                    mode_d[s] = src_mode[s];
                    sign_d[s] = src_sign[s];
                    if (src_sel[s][NumStages-1-s]) begin
                        data_d[s] = shift_stage(src_data[s], src_mode[s], src_sign[s],
                                                32'd1 << (NumStages - 1 - s));
                    end else begin
                        data_d[s] = src_data[s];
                    end
`ifdef SFT_PIPE_STICKY_EN
                    sticky_d[s] = src_sticky[s] |
                                  (src_sel[s][NumStages-1-s] &&
                                   lost_bits(src_data[s], src_mode[s],
                                             32'd1 << (NumStages - 1 - s)));
`endif
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Slice registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NumStages; s++) begin
                data_q[s] <= '0;
                sel_q[s]  <= '0;
                mode_q[s] <= '0;
            end
            sign_q  <= '0;
            valid_q <= '0;
`ifdef SFT_PIPE_STICKY_EN
            sticky_q <= '0;
`endif
        end else begin
            for (int s = 0; s < NumStages; s++) begin
                data_q[s] <= data_d[s];
                sel_q[s]  <= sel_d[s];
                mode_q[s] <= mode_d[s];
            end
            sign_q  <= sign_d;
            valid_q <= valid_d;
`ifdef SFT_PIPE_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign out_valid = valid_q[NumStages-1];
    assign out_data  = data_q[NumStages-1];
`ifdef SFT_PIPE_STICKY_EN
    assign out_sticky = sticky_q[NumStages-1];
`else
    assign out_sticky = 1'b0;
`endif

    // The last slice's control fields have no consumer downstream
    logic unused_last_stage;
    assign unused_last_stage = ^{sel_q[NumStages-1], mode_q[NumStages-1], sign_q[NumStages-1]};

endmodule

// File: tb/tb_sft_pipe_multi.sv
// Self-checking bench for sft_pipe_multi (D_WIDTH=16, SEL_WIDTH=4).
module tb_sft_pipe_multi;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;
`ifdef SFT_PIPE_STICKY_EN
    localparam bit StickyOn = 1'b1;
`else
    localparam bit StickyOn = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sticky;

    sft_pipe_multi #(
        .D_WIDTH   (DW),
        .SEL_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] data;
        logic        st;
        int unsigned acc_cyc;
        bit          lat_chk;
    } sb_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  sel;
        logic [1:0]  mode;
        logic [15:0] exp;
        logic        exp_st;
    } vec_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    logic [15:0] drv_exp = '0;
    logic        drv_st = 1'b0;
    bit          drv_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: whole-amount shifts on the full operand
    function automatic logic [16:0] ref_shift(input logic [15:0] d, input logic [3:0] s,
                                              input logic [1:0] m);
        logic [31:0] dd;
        logic [15:0] r;
        logic [15:0] lost;
        logic        st;
        lost = d & ((16'h1 << s) - 16'h1);
        st   = 1'b0;
        dd   = '0;
        case (m)
            2'b00: r = d << s;
            2'b01: begin r = d >> s; st = |lost; end
            2'b10: begin r = $signed(d) >>> s; st = |lost; end
            default: begin dd = {d, d} << s; r = dd[31:16]; end
        endcase
        return {st, r};
    endfunction

    // Monitor: scoreboard push on input handshake, pop/compare on output handshake
    initial begin
        sb_t         e;
        bit          hold = 1'b0;
        logic [15:0] hold_data = '0;
        logic        hold_st = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(hold_data));
                    check("hold_sticky", 32'(out_sticky), 32'(hold_st));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %0h expected no output", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_sticky", 32'(out_sticky), 32'(e.st));
                        if (e.lat_chk) check("latency", cyc - e.acc_cyc, SW);
                    end
                end
                if (in_valid && in_ready && !flush) begin
                    sb_q.push_back('{data: drv_exp, st: drv_st, acc_cyc: cyc, lat_chk: drv_lat});
                    acc_cnt++;
                end
                if (flush) sb_q.delete();
                hold      = out_valid && !out_ready && !flush;
                hold_data = out_data;
                hold_st   = out_sticky;
            end
        end
    end

    // Present one beat and wait (bounded) for its handshake; returns at posedge+1
    task automatic send(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m,
                        input logic [15:0] exp, input logic st, input bit lat);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_mode  = m;
        drv_exp  = exp;
        drv_st   = st & StickyOn;
        drv_lat  = lat;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for data %0h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[13];
        logic [16:0] r;
        logic [15:0] d;
        int unsigned acc0;

        vecs[0]  = '{16'h8001, 4'd4,  2'b00, 16'h0010, 1'b0};
        vecs[1]  = '{16'h8001, 4'd4,  2'b01, 16'h0800, 1'b1};
        vecs[2]  = '{16'h8001, 4'd4,  2'b10, 16'hF800, 1'b1};
        vecs[3]  = '{16'h8001, 4'd4,  2'b11, 16'h0018, 1'b0};
        vecs[4]  = '{16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0};
        vecs[5]  = '{16'h9ABC, 4'd0,  2'b10, 16'h9ABC, 1'b0};
        vecs[6]  = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0};
        vecs[7]  = '{16'h7FFF, 4'd15, 2'b10, 16'h0000, 1'b1};
        vecs[8]  = '{16'hFFFF, 4'd15, 2'b01, 16'h0001, 1'b1};
        vecs[9]  = '{16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0};
        vecs[10] = '{16'h8000, 4'd1,  2'b11, 16'h0001, 1'b0};
        vecs[11] = '{16'hC003, 4'd9,  2'b11, 16'h0780, 1'b0};
        vecs[12] = '{16'h00F0, 4'd5,  2'b01, 16'h0007, 1'b1};

        // Reset state
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_sel = '0; in_mode = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sticky", 32'(out_sticky), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed mode table, streamed back-to-back
        foreach (vecs[i]) send(vecs[i].data, vecs[i].sel, vecs[i].mode,
                               vecs[i].exp, vecs[i].exp_st, 1'b1);
        in_valid = 1'b0;
        drain();

        // Sweep all sel x mode with random operands
        for (int s = 0; s < 16; s++) begin
            for (int m = 0; m < 4; m++) begin
                d = 16'($urandom);
                r = ref_shift(d, 4'(s), 2'(m));
                send(d, 4'(s), 2'(m), r[15:0], r[16], 1'b1);
            end
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: exactly four beats fit, head holds steady
        out_ready = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 4; i++) send(16'hA000 + 16'(i), 4'd0, 2'b00, 16'hA000 + 16'(i),
                                         1'b0, 1'b0);
        in_valid = 1'b1; in_data = 16'hA004; in_sel = '0; in_mode = '0;
        drv_exp = 16'hA004; drv_st = 1'b0; drv_lat = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'hA000);
        end
        check("bp_accepted", acc_cnt - acc0, 32'd4);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Flush with three beats in flight and a beat offered in the flush cycle
        for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 4'd1, 2'b00, 16'h0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 16'hDEAD; in_sel = '0; in_mode = '0;
        drv_exp = 16'hDEAD; drv_st = 1'b0; drv_lat = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("flush_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0F0F, 4'd4, 2'b11, 16'hF0F0, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset while full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h5000 + 16'(i), 4'd0, 2'b00, 16'h5000 + 16'(i),
                                         1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h1234, 4'd8, 2'b11, 16'h3412, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sft_pipe_multi.md
Name: sft_pipe_multi

Overview:
- Parametrised, pipelined successor of the 16-bit low-fan-in left shifter.
- Same MSB-first log-shift network: largest shift is applied first.
- Adds three things: generic width, four shift modes, and one register slice per stage with valid/ready flow control.
- Sits between the perceptron accumulator and the normalisation / activation logic. Feeds variable shifts at full throughput under backpressure.

Parameters:
- D_WIDTH, 16: data width. Must be a power of two, ≥4.
- SEL_WIDTH, 4: shift-amount width. Must equal log2(D_WIDTH). Also the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  D_WIDTH  operand
- in_sel  input  SEL_WIDTH  shift amount, 0..D_WIDTH-1
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  D_WIDTH  shifted result
- out_sticky  output  1  OR of bits discarded by LSR/ASR (STICKY_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst_n low, async): all stage valid bits = 0, so out_valid = 0 and in_ready = 1. out_data = 0 and out_sticky = 0. Data, sel and mode registers clear to 0.
- Stages:
  - Stage s (s = 0..SEL_WIDTH-1) applies a shift of 2^(SEL_WIDTH-1-s) when sel bit (SEL_WIDTH-1-s) is 1. Otherwise it passes data through.
  - Each stage has a register slice holding data, the remaining sel bits, mode, sticky and valid.
- Latency and throughput: exactly SEL_WIDTH cycles from input handshake to out_valid when no stall occurs. Throughput is 1 beat/cycle.
- Mode fill rules per stage, for shift amount k:
  - LSL: zeros enter at the LSB.
  - LSR: zeros enter at the MSB.
  - ASR: copies of the original bit D_WIDTH-1 enter at the MSB (sign carried from the input, not recomputed per stage).
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Sel = 0: out_data = in_data in every mode; sticky = 0.
- Handshakes:
  - Input is accepted when in_valid and in_ready are both high.
  - Output transfers when out_valid and out_ready are both high.
  - out_data, out_valid and out_sticky must hold stable while out_valid = 1 and out_ready = 0.
- Flow control:
  - Stage s advances when stage s+1 is empty or advancing. The last stage advances on out_ready or when empty.
  - in_ready = (stage 0 empty) or (stage 0 advancing). This is combinational through the bubble-collapsing chain.
  - Bubbles collapse: with out_ready low, the pipe accepts up to SEL_WIDTH beats before in_ready falls.
- Ordering: strictly in order; no beat is dropped or duplicated.
- Simultaneous events:
  - Input accept and output transfer in the same cycle are allowed when full; occupancy is unchanged.
  - flush has priority over everything except reset. On the next edge all valids = 0, and any input beat presented in the flush cycle is discarded (in_ready still reads 1).
- Reset mid-operation: all in-flight beats are lost; the pipe restarts empty.
- Invalid mode/sel combinations: none exist. All 2^(SEL_WIDTH+2) combinations are defined.

Optional Feature:
- Macro SFT_PIPE_STICKY_EN.
- When defined:
  - Each stage ORs the bits it discards during LSR/ASR into a sticky register that travels with the beat.
  - out_sticky reports the total for that beat.
  - LSL and ROL force sticky = 0.
- When undefined: no sticky registers exist and out_sticky is tied 0.

Test Plan:
All scenarios use D_WIDTH=16 and SEL_WIDTH=4.
- Modes:
  - in_data=0x8001, sel=4, LSL → out_data=0x0010 after 4 cycles, sticky=0.
  - in_data=0x8001, sel=4: LSR → 0x0800 (sticky=1); ASR → 0xF800 (sticky=1); ROL → 0x0018 (sticky=0).
- Sweep:
  - Random in_data, all 16 sel values × 4 modes streamed back-to-back with out_ready=1.
  - Required: one result per cycle after 4-cycle fill, all match the reference model, and sel=0 returns the input unchanged.
- Backpressure:
  - Hold out_ready=0 and offer beats 0xA000..0xA004 with sel=0, LSL.
  - Required: exactly 4 are accepted, in_ready drops after the 4th, and out_data stays 0xA000 stable.
  - Raise out_ready: outputs appear in order 0xA000..0xA004, one per cycle.
- Flush:
  - With 3 beats in flight, pulse flush for one cycle.
  - Required: next cycle out_valid=0; a beat offered in the flush cycle never appears; the next new beat emerges 4 cycles after acceptance.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously between edges while full.
  - Required: out_valid=0, out_data=0 and in_ready=1 immediately. After release, the first new beat (0x1234, sel=8, ROL) yields 0x3412.
